// File: rtl/mem_ctrl.sv
// Byte-serialising memory controller: turns a word-wide CPU request with byte
// lane enables into one access per enabled lane on an 8-bit synchronous RAM.
module mem_ctrl #(
  parameter int RAM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mem_rwe_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [3:0]            mem_sel_i,
  input  logic [31:0]           mem_data_i,
  output logic [31:0]           mem_data_o,
  output logic                  mem_busy_o,
  output logic                  mem_done_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [RAM_ADDR_W-1:0] ram_addr_o,
  output logic [7:0]            ram_data_o,
  input  logic [7:0]            ram_data_i
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [RAM_ADDR_W-1:0] base_q, base_d;
  logic [3:0]            sel_q, sel_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rbuf_q, rbuf_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ram_en_q, ram_en_d;
  logic                  ram_we_q, ram_we_d;
  logic [RAM_ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]            ram_data_q, ram_data_d;
  logic                  cap_q, cap_d;
  logic [1:0]            cap_lane_q, cap_lane_d;

  logic [3:0]            pick_sel;
  logic [31:0]           pick_data;
  logic [RAM_ADDR_W-1:0] pick_base;
  logic [1:0]            lane;
  logic                  lane_valid;
  logic                  req_rd, req_wr;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr_i[31:RAM_ADDR_W], mem_addr_i[1:0]};

  assign req_rd = (mem_rwe_i == 2'b01);
  assign req_wr = (mem_rwe_i == 2'b10);

  // In IDLE the first lane is chosen straight from the request inputs so the
  // first strobe can appear in the cycle right after accept.
  always_comb begin
    pick_sel   = (state_q == S_IDLE) ? mem_sel_i : sel_q;
    pick_data  = (state_q == S_IDLE) ? mem_data_i : wdata_q;
    pick_base  = (state_q == S_IDLE) ? {mem_addr_i[RAM_ADDR_W-1:2], 2'b00} : base_q;
    lane_valid = |pick_sel;
    lane       = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pick_sel[i]) lane = 2'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    sel_d      = sel_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ram_en_d   = 1'b0;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    // A read strobe presented last cycle has its byte on ram_data_i now.
    cap_d      = ram_en_q & ~ram_we_q;
    cap_lane_d = ram_addr_q[1:0];
    if (cap_q) rbuf_d[8*cap_lane_q +: 8] = ram_data_i;

    case (state_q)
      S_IDLE: begin
        if (req_rd || req_wr) begin
          base_d  = pick_base;
          wdata_d = mem_data_i;
          busy_d  = 1'b1;
          if (req_rd) rbuf_d = '0;
          if (!lane_valid) begin
            sel_d   = 4'b0000;
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            ram_en_d   = 1'b1;
            ram_we_d   = req_wr;
            ram_addr_d = {pick_base[RAM_ADDR_W-1:2], lane};
            ram_data_d = pick_data[8*lane +: 8];
            sel_d      = pick_sel;
            sel_d[lane] = 1'b0;
            state_d    = req_wr ? S_WRITE : S_READ;
          end
        end
      end
      S_READ, S_WRITE: begin
        if (lane_valid) begin
          ram_en_d    = 1'b1;
          ram_we_d    = (state_q == S_WRITE);
          ram_addr_d  = {pick_base[RAM_ADDR_W-1:2], lane};
          ram_data_d  = pick_data[8*lane +: 8];
          sel_d       = pick_sel;
          sel_d[lane] = 1'b0;
        end else if (state_q == S_WRITE) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      sel_q      <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      cap_q      <= 1'b0;
      cap_lane_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      sel_q      <= sel_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ram_en_q   <= ram_en_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      cap_q      <= cap_d;
      cap_lane_q <= cap_lane_d;
    end
  end

  assign mem_data_o = rbuf_q;
  assign mem_busy_o = busy_q;
  assign mem_done_o = done_q;
  assign ram_en_o   = ram_en_q;
  assign ram_we_o   = ram_we_q;
  assign ram_addr_o = ram_addr_q;
  assign ram_data_o = ram_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed plus randomized bench for mem_ctrl with a behavioural RAM and a
// byte-array reference model of what memory should hold.
module tb_mem_ctrl;
  localparam int AW = 17;

  logic          clk;
  logic          rst;
  logic [1:0]    mem_rwe_i;
  logic [31:0]   mem_addr_i;
  logic [3:0]    mem_sel_i;
  logic [31:0]   mem_data_i;
  logic [31:0]   mem_data_o;
  logic          mem_busy_o;
  logic          mem_done_o;
  logic          ram_en_o;
  logic          ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [7:0]    ram_data_o;
  logic [7:0]    ram_data_i;

  mem_ctrl #(.RAM_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .mem_rwe_i(mem_rwe_i), .mem_addr_i(mem_addr_i), .mem_sel_i(mem_sel_i),
    .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
    .mem_busy_o(mem_busy_o), .mem_done_o(mem_done_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ram     [0:(1<<AW)-1];
  logic [7:0] ref_mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) ram[ram_addr_o] <= ram_data_o;
      else          ram_data_i      <= ram[ram_addr_o];
    end
  end

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input int cycles, input string tag);
    int bad;
    bad = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (mem_busy_o || mem_done_o || ram_en_o) bad++;
    end
    check({tag, "_idle"}, 32'(bad), 32'd0);
  endtask

  task automatic do_req(input logic [1:0] rwe, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] data, input bit hold, input string tag);
    logic [AW-1:0] base;
    int lanes[$];
    int n, exp_done, nstb, done_cyc, busy_bad, k;
    bit is_wr;
    base  = {addr[AW-1:2], 2'b00};
    is_wr = (rwe == 2'b10);
    for (int i = 0; i < 4; i++) if (sel[i]) lanes.push_back(i);
    n = lanes.size();
    exp_done = (n == 0) ? 1 : (is_wr ? n + 1 : n + 2);

    @(negedge clk);
    mem_rwe_i = rwe; mem_addr_i = addr; mem_sel_i = sel; mem_data_i = data;
    @(posedge clk);
    nstb = 0; done_cyc = 0; busy_bad = 0;
    for (int c = 1; c <= 12 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (!hold) mem_rwe_i = 2'b00;
        mem_addr_i = $urandom; mem_sel_i = 4'($urandom); mem_data_i = $urandom;
      end
      if (!mem_busy_o) busy_bad++;
      if (ram_en_o) begin
        if (nstb < n) begin
          k = lanes[nstb];
          check({tag, "_addr"}, 32'(ram_addr_o), 32'(base) + 32'(k));
          check({tag, "_we"}, 32'(ram_we_o), 32'(is_wr));
          check({tag, "_stbcyc"}, 32'(c), 32'(nstb + 1));
          if (is_wr) check({tag, "_wbyte"}, 32'(ram_data_o), 32'(data[8*k +: 8]));
        end
        nstb++;
      end
      if (mem_done_o) done_cyc = c;
    end
    mem_rwe_i = 2'b00;
    check({tag, "_nstrobes"}, 32'(nstb), 32'(n));
    check({tag, "_donecyc"}, 32'(done_cyc), 32'(exp_done));
    check({tag, "_busy"}, 32'(busy_bad), 32'd0);

    if (is_wr) begin
      foreach (lanes[i]) ref_mem[base + AW'(lanes[i])] = data[8*lanes[i] +: 8];
    end else begin
      exp_rdata = 32'h0;
      foreach (lanes[i]) exp_rdata[8*lanes[i] +: 8] = ref_mem[base + AW'(lanes[i])];
    end
    check({tag, "_rdata"}, mem_data_o, exp_rdata);
  endtask

  task automatic idle_req(input logic [1:0] rwe, input string tag);
    @(negedge clk);
    mem_rwe_i = rwe; mem_addr_i = 32'h0000_0500; mem_sel_i = 4'hF; mem_data_i = $urandom;
    idle_check(3, tag);
    mem_rwe_i = 2'b00;
  endtask

  initial begin
    logic [AW-1:0] rbase;
    logic [31:0]   rdat, raddr;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    exp_rdata = 32'h0;
    rst = 1'b1;
    mem_rwe_i = 2'b00; mem_addr_i = 32'h0; mem_sel_i = 4'h0; mem_data_i = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_data_o", mem_data_o, 32'h0);
    check("rst_busy", 32'(mem_busy_o), 32'h0);
    check("rst_done", 32'(mem_done_o), 32'h0);
    check("rst_en", 32'(ram_en_o), 32'h0);
    check("rst_we", 32'(ram_we_o), 32'h0);
    check("rst_addr", 32'(ram_addr_o), 32'h0);
    check("rst_wdata", 32'(ram_data_o), 32'h0);
    rst = 1'b0;

    do_req(2'b10, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 0, "wr_full");
    do_req(2'b01, 32'h0000_0102, 4'b1111, 32'h0, 0, "rd_full");
    check("rd_full_const", mem_data_o, 32'hDEAD_BEEF);
    do_req(2'b01, 32'h0000_0100, 4'b0100, 32'h0, 0, "rd_lane2");
    check("rd_lane2_const", mem_data_o, 32'h00AD_0000);
    do_req(2'b10, 32'h0000_0200, 4'b1010, 32'h1122_3344, 0, "wr_1010");
    do_req(2'b01, 32'h0000_0200, 4'b1111, 32'h0, 0, "rd_1010");
    check("rd_1010_const", mem_data_o, 32'h1100_3300);
    do_req(2'b10, 32'h0000_0400, 4'b0000, 32'hFFFF_FFFF, 0, "wr_sel0");
    do_req(2'b01, 32'h0000_0400, 4'b0000, 32'h0, 0, "rd_sel0");
    do_req(2'b01, 32'h0000_0100, 4'b1111, 32'h0, 1, "rd_hold");
    idle_check(3, "after_hold");
    idle_req(2'b11, "rwe11");
    idle_req(2'b00, "rwe00");

    // Reset early in cycle 2 of a full write: only lane 0 reached the RAM.
    rdat = $urandom;
    @(negedge clk);
    mem_rwe_i = 2'b10; mem_addr_i = 32'h0000_0300; mem_sel_i = 4'hF; mem_data_i = rdat;
    @(posedge clk);
    @(negedge clk);
    mem_rwe_i = 2'b00;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_data_o", mem_data_o, 32'h0);
    check("arst_busy", 32'(mem_busy_o), 32'h0);
    check("arst_done", 32'(mem_done_o), 32'h0);
    check("arst_en", 32'(ram_en_o), 32'h0);
    check("arst_we", 32'(ram_we_o), 32'h0);
    check("arst_addr", 32'(ram_addr_o), 32'h0);
    check("arst_wdata", 32'(ram_data_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ref_mem[AW'(32'h300)] = rdat[7:0];
    exp_rdata = 32'h0;
    idle_check(3, "post_rst");
    do_req(2'b01, 32'h0000_0300, 4'b1111, 32'h0, 0, "rd_after_rst");

    // Random traffic confined to 16 words so reads observe earlier writes;
    // upper address bits are random to exercise truncation.
    for (int t = 0; t < 40; t++) begin
      raddr = ($urandom & 32'hFFFE_0003) | (32'($urandom_range(0, 15)) << 2);
      rbase = AW'(raddr);
      rdat  = $urandom;
      do_req(2'($urandom_range(1, 2)), raddr, 4'($urandom), rdat, 0, $sformatf("rnd%0d_%05h", t, rbase));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
